game_round_ctrl: RTL

- Central sequencer for the colour-match game.
- Owns the game state machine. Arms and clears the game timer, requests a new colour set from the random generator each round, and judges the player's answer against the answer colour.
- Pulses the scorer on a correct answer and drives the game-over signal consumed by the scorer, switch decoder and VGA blocks.
- Sits between the input-decode blocks and the random/timer/scorer/VGA datapath.

---
 rtl/game_pkg.sv | 26 ++
 rtl/cycle_counter.sv | 28 ++
 rtl/game_round_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the colour-match game: sequencer state encoding,
// feedback codes, the default colour width and colour type used by the
// random, switch-decode and VGA blocks, plus a saturating 8-bit increment.
package game_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ROUND,
      FEEDBACK,
      GAME_OVER
   } state_t;

   localparam logic [1:0] FB_NONE    = 2'b00;
   localparam logic [1:0] FB_OK      = 2'b01;
   localparam logic [1:0] FB_WRONG   = 2'b10;
   localparam logic [1:0] FB_TIMEOUT = 2'b11;

   localparam int COLOUR_W_DEFAULT = 3;
   typedef logic [COLOUR_W_DEFAULT-1:0] colour_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/cycle_counter.sv
// Cycle counter with synchronous clear/enable and a terminal-count flag.
// Ports: clk, reset (sync, active-high), clear (sync zero), enable (count),
//        done (high while the count equals TERMINAL; the count holds there).
module cycle_counter #(
   parameter int unsigned TERMINAL = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic done
);

   localparam int W = (TERMINAL > 0) ? $clog2(TERMINAL + 1) : 1;

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && !done) begin
         count <= count + 1'b1;
      end
   end

   assign done = (count == W'(TERMINAL));

endmodule

// File: rtl/game_round_ctrl.sv
// Central sequencer for the colour-match game: owns the game FSM, arms/clears
// the game timer, requests new colour sets, judges answers and drives the
// scorer pulse and game-over level.
// Ports: CLOCK_50, reset (sync, active-high), start, answer_valid,
//        answer_colour, target_colour, timer_expired -> new_round, timer_run,
//        timer_clear, score_inc, game_over, feedback, round_num [, lives].
// Optional: define GAME_ROUND_LIVES_EN to add a 2-bit lives output; wrong
//        answers and round timeouts then cost a life and the game ends after
//        the feedback window in which lives reach zero.
module game_round_ctrl
   import game_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 50000000,
   parameter int unsigned FEEDBACK_MS  = 250,
   parameter int unsigned ROUND_CYCLES = 250000000,
   parameter int          COLOUR_W     = 3
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic                start,
   input  logic                answer_valid,
   input  logic [COLOUR_W-1:0] answer_colour,
   input  logic [COLOUR_W-1:0] target_colour,
   input  logic                timer_expired,
   output logic                new_round,
   output logic                timer_run,
   output logic                timer_clear,
   output logic                score_inc,
   output logic                game_over,
   output logic [1:0]          feedback,
`ifdef GAME_ROUND_LIVES_EN
   output logic [1:0]          lives,
`endif
   output logic [7:0]          round_num
);

   // The ms*Hz product overflows 32 bits at default settings, so widen first.
   localparam int unsigned FB_CYCLES = 32'((64'(FEEDBACK_MS) * 64'(CLK_HZ)) / 64'd1000);
   localparam int unsigned FB_TERM   = (FB_CYCLES > 0) ? FB_CYCLES - 1 : 0;
   localparam int unsigned RND_TERM  = (ROUND_CYCLES > 0) ? ROUND_CYCLES - 1 : 0;

   state_t     state, state_nxt;
   logic [1:0] fb_nxt;
   logic [7:0] rn_nxt;
   logic       rnd_done, fb_done;
   logic       colour_match;
   logic       out_of_lives;

   assign colour_match = (answer_colour == target_colour);

   // Both counters sit at zero outside their own state, so each state visit
   // starts a fresh count without an explicit clear pulse.
   cycle_counter #(.TERMINAL(RND_TERM)) u_round_cnt (
      .clk    (CLOCK_50),
      .reset  (reset),
      .clear  (state != ROUND),
      .enable (state == ROUND),
      .done   (rnd_done)
   );

   cycle_counter #(.TERMINAL(FB_TERM)) u_fb_cnt (
      .clk    (CLOCK_50),
      .reset  (reset),
      .clear  (state != FEEDBACK),
      .enable (state == FEEDBACK),
      .done   (fb_done)
   );

`ifdef GAME_ROUND_LIVES_EN
   logic miss;

   // Same priority as the FSM: an expired game timer swallows the answer.
   assign miss = (state == ROUND) && !timer_expired &&
                 ((answer_valid && !colour_match) || (!answer_valid && rnd_done));

   always_ff @(posedge CLOCK_50) begin
      if (reset || timer_clear) begin
         lives <= 2'd3;
      end else if (miss && (lives != 2'd0)) begin
         lives <= lives - 2'd1;
      end
   end

   assign out_of_lives = (lives == 2'd0);
`else
   assign out_of_lives = 1'b0;
`endif

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state     <= IDLE;
         feedback  <= FB_NONE;
         round_num <= 8'd0;
      end else begin
         state     <= state_nxt;
         feedback  <= fb_nxt;
         round_num <= rn_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      fb_nxt      = feedback;
      rn_nxt      = round_num;
      new_round   = 1'b0;
      timer_run   = 1'b0;
      timer_clear = 1'b0;
      score_inc   = 1'b0;
      game_over   = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               timer_clear = 1'b1;
               rn_nxt      = 8'd0;
               fb_nxt      = FB_NONE;
               state_nxt   = LOAD;
            end
         end

         LOAD: begin
            new_round = 1'b1;
            rn_nxt    = sat_inc8(round_num);
            state_nxt = ROUND;
         end

         ROUND: begin
            timer_run = 1'b1;
            if (timer_expired) begin
               fb_nxt    = FB_NONE;
               state_nxt = GAME_OVER;
            end else if (answer_valid) begin
               score_inc = colour_match;
               fb_nxt    = colour_match ? FB_OK : FB_WRONG;
               state_nxt = FEEDBACK;
            end else if (rnd_done) begin
               fb_nxt    = FB_TIMEOUT;
               state_nxt = FEEDBACK;
            end
         end

         FEEDBACK: begin
            timer_run = 1'b1;
            if (timer_expired) begin
               fb_nxt    = FB_NONE;
               state_nxt = GAME_OVER;
            end else if (fb_done) begin
               fb_nxt    = FB_NONE;
               state_nxt = out_of_lives ? GAME_OVER : LOAD;
            end
         end

         GAME_OVER: begin
            game_over = 1'b1;
            fb_nxt    = FB_NONE;
            if (start) begin
               timer_clear = 1'b1;
               rn_nxt      = 8'd0;
               state_nxt   = LOAD;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
